// File: rtl/frame_buffer_swap_ctrl_pkg.sv
// rtl/frame_buffer_swap_ctrl_pkg.sv - shared FSM states and pixel-word width for the frame buffer.
package frame_buffer_swap_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        SWAP    = 2'd2,
        CLEAR   = 2'd3
    } swap_state_e;

    // Pixel word carries three colour channels per panel segment.
    function automatic int pixel_width(input int bitwidth, input int segments);
        return bitwidth * 3 * segments;
    endfunction

endpackage

// File: rtl/frame_buffer_bank.sv
// rtl/frame_buffer_bank.sv - simple dual-port pixel RAM, one write port, one registered read port.
module frame_buffer_bank #(
    parameter int DEPTH = 256,
    parameter int WIDTH = 24,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [WIDTH-1:0]  wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [WIDTH-1:0]  rdata_o
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    // Only the read register is reset; array contents survive reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= mem[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/frame_buffer_swap_ctrl.sv
// rtl/frame_buffer_swap_ctrl.sv - double-buffered frame store swapping banks at display frame boundaries.
module frame_buffer_swap_ctrl
    import frame_buffer_swap_ctrl_pkg::*;
#(
    parameter int segments = 1,
    parameter int rows     = 8,
    parameter int columns  = 32,
    parameter int bitwidth = 8,
    localparam int ROW_W   = $clog2(rows),
    localparam int COL_W   = $clog2(columns),
    localparam int ADDR_W  = ROW_W + COL_W,
    localparam int PIX_W   = pixel_width(bitwidth, segments)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [ROW_W-1:0] rd_row_i,
    input  logic [COL_W-1:0] rd_column_i,
    output logic [PIX_W-1:0] rd_pixel_o,
    input  logic             frame_complete_i,
    input  logic             wr_valid_i,
    output logic             wr_ready_o,
    input  logic [ROW_W-1:0] wr_row_i,
    input  logic [COL_W-1:0] wr_column_i,
    input  logic [PIX_W-1:0] wr_data_i,
    input  logic             swap_req_i,
    input  logic             clear_en_i,
    output logic             swap_done_o,
    output logic             busy_o,
    output logic             front_sel_o
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(rows * columns - 1);

    swap_state_e       state_q;
    logic              front_sel_q;
    logic              rd_sel_q;
    logic              clr_q;
    logic              busy_q;
    logic              swap_done_q;
    logic [ADDR_W-1:0] clr_addr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            front_sel_q <= 1'b0;
            clr_q       <= 1'b0;
            busy_q      <= 1'b0;
            swap_done_q <= 1'b0;
            clr_addr_q  <= '0;
        end else begin
            swap_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (swap_req_i) begin
                        state_q <= PENDING;
                        clr_q   <= clear_en_i;
                        busy_q  <= 1'b1;
                    end
                end
                PENDING: begin
                    // front_sel is registered on entry so it is already new during SWAP.
                    if (frame_complete_i) begin
                        state_q     <= SWAP;
                        front_sel_q <= ~front_sel_q;
                    end
                end
                SWAP: begin
                    if (clr_q) begin
                        state_q    <= CLEAR;
                        clr_addr_q <= '0;
                    end else begin
                        state_q     <= IDLE;
                        busy_q      <= 1'b0;
                        swap_done_q <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (clr_addr_q == LAST_ADDR) begin
                        state_q     <= IDLE;
                        busy_q      <= 1'b0;
                        swap_done_q <= 1'b1;
                        clr_addr_q  <= '0;
                    end else begin
                        clr_addr_q <= clr_addr_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Remember which bank each read was issued against so in-flight reads survive a swap.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_sel_q <= 1'b0;
        end else begin
            rd_sel_q <= front_sel_q;
        end
    end

    logic              clearing;
    logic              back_we;
    logic [ADDR_W-1:0] back_addr;
    logic [PIX_W-1:0]  back_data;
    logic [1:0]        bank_we;
    logic [PIX_W-1:0]  bank_rdata [2];

    assign wr_ready_o = (state_q == IDLE) && !rst;
    assign clearing   = (state_q == CLEAR);
    assign back_we    = (wr_valid_i && wr_ready_o) || clearing;
    assign back_addr  = clearing ? clr_addr_q : {wr_row_i, wr_column_i};
    assign back_data  = clearing ? '0 : wr_data_i;
    assign bank_we    = {back_we & ~front_sel_q, back_we & front_sel_q};

    for (genvar b = 0; b < 2; b++) begin : g_bank
        frame_buffer_bank #(
            .DEPTH(rows * columns),
            .WIDTH(PIX_W)
        ) u_bank (
            .clk    (clk),
            .rst    (rst),
            .we_i   (bank_we[b]),
            .waddr_i(back_addr),
            .wdata_i(back_data),
            .raddr_i({rd_row_i, rd_column_i}),
            .rdata_o(bank_rdata[b])
        );
    end

    assign rd_pixel_o  = rd_sel_q ? bank_rdata[1] : bank_rdata[0];
    assign swap_done_o = swap_done_q;
    assign busy_o      = busy_q;
    assign front_sel_o = front_sel_q;

endmodule

// File: tb/tb_frame_buffer_swap_ctrl.sv
// tb/tb_frame_buffer_swap_ctrl.sv - self-checking bench for frame_buffer_swap_ctrl.
module tb_frame_buffer_swap_ctrl;

    localparam int DEPTH = 256;
    localparam int PW    = 24;

    logic          clk = 1'b0;
    logic          rst;
    logic [2:0]    rd_row;
    logic [4:0]    rd_col;
    logic [PW-1:0] rd_pixel;
    logic          frame_complete;
    logic          wr_valid;
    logic          wr_ready;
    logic [2:0]    wr_row;
    logic [4:0]    wr_col;
    logic [PW-1:0] wr_data;
    logic          swap_req;
    logic          clear_en;
    logic          swap_done;
    logic          busy;
    logic          front_sel;

    int            vectors = 0;
    int            miscompares = 0;
    logic [PW-1:0] mdl [2][DEPTH];
    bit            known [2][DEPTH];
    int            mfront = 0;
    logic [PW-1:0] exp_q [$];
    logic [PW-1:0] exp_val;
    logic          rd_chk = 1'b0;
    logic          chk_d = 1'b0;

    always #5 clk = ~clk;

    frame_buffer_swap_ctrl #(
        .segments(1),
        .rows(8),
        .columns(32),
        .bitwidth(8)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .rd_row_i        (rd_row),
        .rd_column_i     (rd_col),
        .rd_pixel_o      (rd_pixel),
        .frame_complete_i(frame_complete),
        .wr_valid_i      (wr_valid),
        .wr_ready_o      (wr_ready),
        .wr_row_i        (wr_row),
        .wr_column_i     (wr_col),
        .wr_data_i       (wr_data),
        .swap_req_i      (swap_req),
        .clear_en_i      (clear_en),
        .swap_done_o     (swap_done),
        .busy_o          (busy),
        .front_sel_o     (front_sel)
    );

    // Scoreboard: expected pixel pushed when the address is driven, popped one cycle later.
    always @(posedge clk) chk_d <= rd_chk;

    always @(negedge clk) begin
        if (chk_d) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL rd_pixel: got %h with empty scoreboard", rd_pixel);
            end else begin
                exp_val = exp_q.pop_front();
                if (rd_pixel !== exp_val) begin
                    miscompares++;
                    $display("FAIL rd_pixel: got %h expected %h", rd_pixel, exp_val);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic present_read(input int addr);
        rd_row = addr[7:5];
        rd_col = addr[4:0];
        rd_chk = 1'b1;
        exp_q.push_back(mdl[mfront][addr]);
    endtask

    task automatic request_swap(input logic clr, input int gap);
        swap_req = 1'b1;
        clear_en = clr;
        next_cycle;
        swap_req = 1'b0;
        clear_en = 1'b0;
        repeat (gap) next_cycle;
        frame_complete = 1'b1;
        next_cycle;
        frame_complete = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        rd_row = '0; rd_col = '0; frame_complete = 1'b0; wr_valid = 1'b0;
        wr_row = '0; wr_col = '0; wr_data = '0; swap_req = 1'b0; clear_en = 1'b0;
        repeat (3) next_cycle;
        @(negedge clk);
        vectors += 5;
        if (wr_ready !== 1'b0)  begin miscompares++; $display("FAIL reset_wr_ready: got %b expected 0", wr_ready); end
        if (rd_pixel !== '0)    begin miscompares++; $display("FAIL reset_rd_pixel: got %h expected 0", rd_pixel); end
        if (front_sel !== 1'b0) begin miscompares++; $display("FAIL reset_front_sel: got %b expected 0", front_sel); end
        if (busy !== 1'b0)      begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
        if (swap_done !== 1'b0) begin miscompares++; $display("FAIL reset_swap_done: got %b expected 0", swap_done); end
        next_cycle;
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (wr_ready !== 1'b1) begin miscompares++; $display("FAIL idle_wr_ready: got %b expected 1", wr_ready); end
        next_cycle;
    endtask

    task automatic test_clear_swap;
        int  n;
        bit  ready_seen;
        int  old_front;
        old_front = mfront;
        request_swap(1'b1, 3);
        n = 0;
        ready_seen = 0;
        @(negedge clk);
        while (busy === 1'b1 && n < 400) begin
            n++;
            if (wr_ready !== 1'b0) ready_seen = 1;
            next_cycle;
            @(negedge clk);
        end
        vectors += 4;
        if (n != 257)                     begin miscompares++; $display("FAIL clear_busy_cycles: got %0d expected 257", n); end
        if (ready_seen)                   begin miscompares++; $display("FAIL clear_wr_ready: got 1 during swap expected 0"); end
        if (swap_done !== 1'b1)           begin miscompares++; $display("FAIL clear_swap_done: got %b expected 1", swap_done); end
        if (front_sel !== 1'(1 - old_front)) begin miscompares++; $display("FAIL clear_front_sel: got %b expected %0d", front_sel, 1 - old_front); end
        next_cycle;
        @(negedge clk);
        vectors++;
        if (swap_done !== 1'b0) begin miscompares++; $display("FAIL clear_swap_done_pulse: got %b expected 0", swap_done); end
        mfront = 1 - old_front;
        for (int a = 0; a < DEPTH; a++) begin
            mdl[1 - mfront][a] = '0;
            known[1 - mfront][a] = 1;
        end
        next_cycle;
    endtask

    task automatic test_read_all;
        for (int a = 0; a < DEPTH; a++) begin
            present_read(a);
            next_cycle;
        end
        rd_chk = 1'b0;
        next_cycle;
    endtask

    task automatic test_basic_swap;
        wr_valid = 1'b1; wr_row = 3'd2; wr_col = 5'd5; wr_data = 24'h112233;
        @(negedge clk);
        vectors++;
        if (wr_ready !== 1'b1) begin miscompares++; $display("FAIL basic_wr_ready: got %b expected 1", wr_ready); end
        mdl[1 - mfront][2 * 32 + 5] = 24'h112233;
        next_cycle;
        wr_valid = 1'b0;
        swap_req = 1'b1;
        clear_en = 1'b0;
        next_cycle;
        swap_req = 1'b0;
        @(negedge clk);
        vectors += 2;
        if (busy !== 1'b1)     begin miscompares++; $display("FAIL pending_busy: got %b expected 1", busy); end
        if (wr_ready !== 1'b0) begin miscompares++; $display("FAIL pending_wr_ready: got %b expected 0", wr_ready); end
        repeat (19) next_cycle;
        frame_complete = 1'b1;
        present_read(2 * 32 + 5);
        @(negedge clk);
        vectors++;
        if (front_sel !== 1'b0) begin miscompares++; $display("FAIL pulse_front_sel: got %b expected 0", front_sel); end
        next_cycle;
        frame_complete = 1'b0;
        rd_chk = 1'b0;
        @(negedge clk);
        vectors += 2;
        if (front_sel !== 1'b1) begin miscompares++; $display("FAIL swap_front_sel: got %b expected 1", front_sel); end
        if (swap_done !== 1'b0) begin miscompares++; $display("FAIL swap_early_done: got %b expected 0", swap_done); end
        mfront = 1;
        next_cycle;
        present_read(2 * 32 + 5);
        @(negedge clk);
        vectors += 3;
        if (swap_done !== 1'b1) begin miscompares++; $display("FAIL basic_swap_done: got %b expected 1", swap_done); end
        if (busy !== 1'b0)      begin miscompares++; $display("FAIL basic_busy: got %b expected 0", busy); end
        if (wr_ready !== 1'b1)  begin miscompares++; $display("FAIL basic_wr_ready_after: got %b expected 1", wr_ready); end
        next_cycle;
        rd_chk = 1'b0;
        @(negedge clk);
        vectors++;
        if (swap_done !== 1'b0) begin miscompares++; $display("FAIL basic_swap_done_pulse: got %b expected 0", swap_done); end
        next_cycle;
    endtask

    task automatic test_write_through_swap;
        logic exp_rdy;
        wr_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            wr_row = 3'd7;
            wr_col = 5'(i);
            wr_data = 24'hA00000 + PW'(i);
            swap_req = (i == 3);
            exp_rdy = (i <= 3);
            @(negedge clk);
            vectors++;
            if (wr_ready !== exp_rdy) begin miscompares++; $display("FAIL wt_wr_ready[%0d]: got %b expected %b", i, wr_ready, exp_rdy); end
            if (exp_rdy) mdl[1 - mfront][7 * 32 + i] = wr_data;
            next_cycle;
        end
        wr_valid = 1'b0;
        swap_req = 1'b0;
        frame_complete = 1'b1;
        next_cycle;
        frame_complete = 1'b0;
        @(negedge clk);
        vectors++;
        if (front_sel !== 1'(1 - mfront)) begin miscompares++; $display("FAIL wt_front_sel: got %b expected %0d", front_sel, 1 - mfront); end
        mfront = 1 - mfront;
        next_cycle;
        @(negedge clk);
        vectors++;
        if (swap_done !== 1'b1) begin miscompares++; $display("FAIL wt_swap_done: got %b expected 1", swap_done); end
        next_cycle;
        for (int i = 0; i < 12; i++) begin
            present_read(7 * 32 + i);
            next_cycle;
        end
        rd_chk = 1'b0;
        next_cycle;
    endtask

    task automatic test_frame_complete_ignored;
        frame_complete = 1'b1;
        next_cycle;
        frame_complete = 1'b0;
        @(negedge clk);
        vectors += 2;
        if (busy !== 1'b0)                begin miscompares++; $display("FAIL idle_fc_busy: got %b expected 0", busy); end
        if (front_sel !== 1'(mfront))     begin miscompares++; $display("FAIL idle_fc_front_sel: got %b expected %0d", front_sel, mfront); end
        repeat (2) next_cycle;
        swap_req = 1'b1;
        frame_complete = 1'b1;
        next_cycle;
        swap_req = 1'b0;
        frame_complete = 1'b0;
        repeat (3) next_cycle;
        swap_req = 1'b1;
        clear_en = 1'b1;
        next_cycle;
        swap_req = 1'b0;
        clear_en = 1'b0;
        repeat (4) next_cycle;
        @(negedge clk);
        vectors += 2;
        if (busy !== 1'b1)            begin miscompares++; $display("FAIL same_cycle_fc_busy: got %b expected 1", busy); end
        if (front_sel !== 1'(mfront)) begin miscompares++; $display("FAIL same_cycle_fc_front_sel: got %b expected %0d", front_sel, mfront); end
        next_cycle;
        frame_complete = 1'b1;
        next_cycle;
        frame_complete = 1'b0;
        @(negedge clk);
        vectors++;
        if (front_sel !== 1'(1 - mfront)) begin miscompares++; $display("FAIL late_fc_front_sel: got %b expected %0d", front_sel, 1 - mfront); end
        mfront = 1 - mfront;
        next_cycle;
        @(negedge clk);
        vectors += 2;
        if (swap_done !== 1'b1) begin miscompares++; $display("FAIL ignored_req_swap_done: got %b expected 1", swap_done); end
        if (busy !== 1'b0)      begin miscompares++; $display("FAIL ignored_req_busy: got %b expected 0", busy); end
        repeat (3) next_cycle;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL no_queued_req_busy: got %b expected 0", busy); end
        next_cycle;
    endtask

    task automatic test_reset_mid_clear;
        bit done_seen;
        request_swap(1'b1, 2);
        repeat (51) next_cycle;
        rst = 1'b1;
        @(negedge clk);
        vectors += 2;
        if (busy !== 1'b1)     begin miscompares++; $display("FAIL mid_clear_busy: got %b expected 1", busy); end
        if (wr_ready !== 1'b0) begin miscompares++; $display("FAIL rst_wr_ready: got %b expected 0", wr_ready); end
        next_cycle;
        rst = 1'b0;
        @(negedge clk);
        vectors += 5;
        if (busy !== 1'b0)      begin miscompares++; $display("FAIL rst_busy: got %b expected 0", busy); end
        if (front_sel !== 1'b0) begin miscompares++; $display("FAIL rst_front_sel: got %b expected 0", front_sel); end
        if (swap_done !== 1'b0) begin miscompares++; $display("FAIL rst_swap_done: got %b expected 0", swap_done); end
        if (wr_ready !== 1'b1)  begin miscompares++; $display("FAIL rst_wr_ready_after: got %b expected 1", wr_ready); end
        if (rd_pixel !== '0)    begin miscompares++; $display("FAIL rst_rd_pixel: got %h expected 0", rd_pixel); end
        done_seen = 0;
        for (int i = 0; i < 5; i++) begin
            next_cycle;
            @(negedge clk);
            if (swap_done !== 1'b0) done_seen = 1;
        end
        vectors++;
        if (done_seen) begin miscompares++; $display("FAIL rst_no_swap_done: got 1 expected 0"); end
        mfront = 0;
        for (int a = 0; a < DEPTH; a++) known[1][a] = 0;
        next_cycle;
    endtask

    task automatic test_random_traffic;
        int waddrs [$];
        int ra;
        int wa;
        bit not_ready;
        not_ready = 0;
        for (int i = 0; i < 200; i++) begin
            ra = int'($urandom_range(0, DEPTH - 1));
            if (known[mfront][ra]) present_read(ra);
            else rd_chk = 1'b0;
            wa = int'($urandom_range(0, DEPTH - 1));
            wr_valid = 1'($urandom_range(0, 1));
            wr_row = wa[7:5];
            wr_col = wa[4:0];
            wr_data = PW'($urandom);
            if (wr_valid) begin
                mdl[1 - mfront][wa] = wr_data;
                known[1 - mfront][wa] = 1;
                waddrs.push_back(wa);
            end
            @(negedge clk);
            if (wr_ready !== 1'b1) not_ready = 1;
            next_cycle;
        end
        wr_valid = 1'b0;
        rd_chk = 1'b0;
        vectors++;
        if (not_ready) begin miscompares++; $display("FAIL rand_wr_ready: got 0 in idle expected 1"); end
        next_cycle;
        request_swap(1'b0, 3);
        next_cycle;
        @(negedge clk);
        vectors++;
        if (swap_done !== 1'b1) begin miscompares++; $display("FAIL rand_swap_done: got %b expected 1", swap_done); end
        mfront = 1 - mfront;
        next_cycle;
        for (int i = 0; i < 64; i++) begin
            if (waddrs.size() > 0) present_read(waddrs[$urandom_range(0, waddrs.size() - 1)]);
            next_cycle;
        end
        rd_chk = 1'b0;
        next_cycle;
        next_cycle;
    endtask

    initial begin
        for (int b = 0; b < 2; b++) begin
            for (int a = 0; a < DEPTH; a++) begin
                mdl[b][a] = '0;
                known[b][a] = 0;
            end
        end
        test_reset;
        test_clear_swap;
        test_clear_swap;
        test_read_all;
        test_basic_swap;
        test_write_through_swap;
        test_frame_complete_ignored;
        test_reset_mid_clear;
        test_random_traffic;
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
